// File: rtl/cd101_pkg.sv
// Shared ADSR definitions: default envelope width and state codes.
// Used by adsr_ctrl and sat_step.
package cd101_pkg;

  localparam int W_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

endpackage

// File: rtl/adsr_ctrl_sat_step.sv
// sat_step: one saturating envelope step toward a bound.
// Adds or subtracts rate and clamps at bound, flagging arrival.
module sat_step
  import cd101_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] val,
  input  logic [W-1:0] rate,
  input  logic [W-1:0] bound,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         reach
);

  logic [W:0]        sum;
  logic signed [W:0] diff;

  always_comb begin
    sum   = {1'b0, val} + {1'b0, rate};
    diff  = $signed({1'b0, val}) - $signed({1'b0, rate});
    res   = val;
    reach = 1'b0;
    // A zero rate freezes the level and never counts as arriving.
    if (rate != '0) begin
      if (sub) begin
        if (diff <= $signed({1'b0, bound})) begin
          res   = bound;
          reach = 1'b1;
        end else begin
          res = diff[W-1:0];
        end
      end else begin
        if (sum >= {1'b0, bound}) begin
          res   = bound;
          reach = 1'b1;
        end else begin
          res = sum[W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/adsr_ctrl.sv
// ADSR envelope controller with gate edge detection and tick stepping.
// Define ADSR_RETRIGGER_EN for hard retrigger (env cleared on rise).
module adsr_ctrl
  import cd101_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         tick,
  input  logic         gate,
  input  logic [W-1:0] attack_rate,
  input  logic [W-1:0] decay_rate,
  input  logic [W-1:0] sustain_level,
  input  logic [W-1:0] release_rate,
  output logic [W-1:0] env,
  output logic [2:0]   state,
  output logic         active
);

  logic [W-1:0] env_q, env_d;
  logic [2:0]   st_q, st_d;
  logic         gate_q;
  logic         rise, fall;

  logic [W-1:0] s_rate, s_bound, s_res;
  logic         s_sub, s_reach;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  always_comb begin
    s_rate  = release_rate;
    s_bound = '0;
    s_sub   = 1'b1;
    case (st_q)
      ST_ATTACK: begin
        s_rate  = attack_rate;
        s_bound = '1;
        s_sub   = 1'b0;
      end
      ST_DECAY: begin
        s_rate  = decay_rate;
        s_bound = sustain_level;
      end
      default: ;
    endcase
  end

  sat_step #(.W(W)) u_step (
    .val   (env_q),
    .rate  (s_rate),
    .bound (s_bound),
    .sub   (s_sub),
    .res   (s_res),
    .reach (s_reach)
  );

  always_comb begin
    st_d  = st_q;
    env_d = env_q;
    if (rise) begin
      st_d = ST_ATTACK;
`ifdef ADSR_RETRIGGER_EN
      env_d = '0;
`endif
    end else if (fall && (st_q == ST_ATTACK ||
                          st_q == ST_DECAY ||
                          st_q == ST_SUSTAIN)) begin
      st_d = ST_RELEASE;
    end else begin
      case (st_q)
        ST_IDLE: env_d = '0;
        ST_SUSTAIN: env_d = sustain_level;
        ST_ATTACK: if (tick) begin
          env_d = s_res;
          if (s_reach) st_d = ST_DECAY;
        end
        ST_DECAY: if (tick) begin
          env_d = s_res;
          if (s_reach) st_d = ST_SUSTAIN;
        end
        ST_RELEASE: if (tick) begin
          env_d = s_res;
          if (s_reach) st_d = ST_IDLE;
        end
        default: begin
          st_d  = ST_IDLE;
          env_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      st_q   <= ST_IDLE;
      env_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      env_q  <= env_d;
      gate_q <= gate;
    end
  end

  assign env    = env_q;
  assign state  = st_q;
  assign active = (st_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_ctrl.sv
// Randomised and directed bench for adsr_ctrl against a
// phase-level behavioural envelope model.
module tb_adsr_ctrl;

`ifdef ADSR_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       tick = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] attack_rate = '0;
  logic [7:0] decay_rate = '0;
  logic [7:0] sustain_level = '0;
  logic [7:0] release_rate = '0;
  logic [7:0] env;
  logic [2:0] state;
  logic       active;

  int checks = 0;
  int passed = 0;

  int m_env = 0;
  int m_st = 0;
  bit m_gq = 1'b0;

  adsr_ctrl #(.W(8)) dut (
    .clk           (clk),
    .arst          (arst),
    .tick          (tick),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .env           (env),
    .state         (state),
    .active        (active)
  );

  always #5 clk = ~clk;

  // Phase numbers: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  function automatic void model_step();
    bit r, f;
    int a, d, s, rl;
    r = gate && !m_gq;
    f = !gate && m_gq;
    m_gq = gate;
    a = int'(attack_rate);
    d = int'(decay_rate);
    s = int'(sustain_level);
    rl = int'(release_rate);
    if (r) begin
      if (RETRIG && m_st != 0) m_env = 0;
      m_st = 1;
    end else if (f && m_st >= 1 && m_st <= 3) begin
      m_st = 4;
    end else if (m_st == 3) begin
      m_env = s;
    end else if (tick) begin
      if (m_st == 1 && a != 0) begin
        m_env = (m_env + a >= 255) ? 255 : m_env + a;
        if (m_env == 255) m_st = 2;
      end else if (m_st == 2 && d != 0) begin
        if (m_env - d <= s) begin
          m_env = s;
          m_st = 3;
        end else begin
          m_env = m_env - d;
        end
      end else if (m_st == 4 && rl != 0) begin
        m_env = (m_env - rl <= 0) ? 0 : m_env - rl;
        if (m_env == 0) m_st = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_env = 0;
    m_st = 0;
    m_gq = 1'b0;
  endfunction

  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (env !== 8'd0)
      $display("FAIL reset_env got=%0d want=0", env);
    else passed++;
    checks++;
    if (state !== 3'd0)
      $display("FAIL reset_state got=%0d want=0", state);
    else passed++;
    checks++;
    if (active !== 1'b0)
      $display("FAIL reset_active got=%0b want=0", active);
    else passed++;
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_adsr_cycle();
    int exp_env[12] = '{64, 128, 192, 255, 239, 223,
                        207, 191, 175, 159, 143, 128};
    attack_rate = 8'd64;
    decay_rate = 8'd16;
    sustain_level = 8'd128;
    release_rate = 8'd32;
    gate = 1'b1;
    adv();
    checks++;
    if (state !== 3'd1)
      $display("FAIL cyc_attack_entry got=%0d want=1", state);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      tick = 1'b1;
      adv();
      tick = 1'b0;
      checks++;
      if (env !== 8'(exp_env[i]))
        $display("FAIL cyc_env%0d got=%0d want=%0d",
                 i, env, exp_env[i]);
      else passed++;
      checks++;
      if (env !== 8'(m_env) || state !== 3'(m_st))
        $display("FAIL cyc_model%0d got=%0d/%0d want=%0d/%0d",
                 i, env, state, m_env, m_st);
      else passed++;
      repeat (3) adv();
    end
    checks++;
    if (state !== 3'd3)
      $display("FAIL cyc_sustain got=%0d want=3", state);
    else passed++;
  endtask

  task automatic test_release();
    int exp_env[4] = '{96, 64, 32, 0};
    gate = 1'b0;
    adv();
    checks++;
    if (state !== 3'd4 || env !== 8'd128)
      $display("FAIL rel_entry got=%0d/%0d want=4/128",
               state, env);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      adv();
      tick = 1'b0;
      checks++;
      if (env !== 8'(exp_env[i]))
        $display("FAIL rel_env%0d got=%0d want=%0d",
                 i, env, exp_env[i]);
      else passed++;
      repeat (3) adv();
    end
    checks++;
    if (state !== 3'd0 || active !== 1'b0)
      $display("FAIL rel_idle got=%0d/%0b want=0/0",
               state, active);
    else passed++;
  endtask

  task automatic test_retrigger();
    int want;
    do_reset();
    sustain_level = 8'd100;
    attack_rate = 8'd255;
    decay_rate = 8'd200;
    gate = 1'b1;
    adv();
    tick = 1'b1;
    adv();
    adv();
    tick = 1'b0;
    gate = 1'b0;
    adv();
    checks++;
    if (state !== 3'd4 || env !== 8'd100)
      $display("FAIL rtg_setup got=%0d/%0d want=4/100",
               state, env);
    else passed++;
    gate = 1'b1;
    adv();
    want = RETRIG ? 0 : 100;
    checks++;
    if (state !== 3'd1 || env !== 8'(want))
      $display("FAIL rtg_rise got=%0d/%0d want=1/%0d",
               state, env, want);
    else passed++;
  endtask

  task automatic test_zero_rate();
    do_reset();
    attack_rate = 8'd0;
    sustain_level = 8'd128;
    gate = 1'b1;
    adv();
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1;
      adv();
      tick = 1'b0;
      adv();
      checks++;
      if (env !== 8'd0 || state !== 3'd1)
        $display("FAIL zr_hold%0d got=%0d/%0d want=0/1",
                 i, env, state);
      else passed++;
    end
    attack_rate = 8'd255;
    decay_rate = 8'd255;
    tick = 1'b1;
    adv();
    adv();
    tick = 1'b0;
    checks++;
    if (state !== 3'd3 || env !== 8'd128)
      $display("FAIL zr_sus got=%0d/%0d want=3/128",
               state, env);
    else passed++;
    sustain_level = 8'd200;
    adv();
    checks++;
    if (env !== 8'd200)
      $display("FAIL zr_track got=%0d want=200", env);
    else passed++;
  endtask

  task automatic test_coincident();
    int want;
    do_reset();
    attack_rate = 8'd255;
    decay_rate = 8'd16;
    sustain_level = 8'd10;
    release_rate = 8'd50;
    gate = 1'b1;
    adv();
    tick = 1'b1;
    adv();
    tick = 1'b1;
    gate = 1'b0;
    adv();
    tick = 1'b0;
    checks++;
    if (state !== 3'd4 || env !== 8'd255)
      $display("FAIL co_fall got=%0d/%0d want=4/255",
               state, env);
    else passed++;
    tick = 1'b1;
    adv();
    tick = 1'b1;
    gate = 1'b1;
    adv();
    tick = 1'b0;
    want = RETRIG ? 0 : 205;
    checks++;
    if (state !== 3'd1 || env !== 8'(want))
      $display("FAIL co_rise got=%0d/%0d want=1/%0d",
               state, env, want);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    attack_rate = 8'd255;
    decay_rate = 8'd75;
    sustain_level = 8'd0;
    gate = 1'b1;
    adv();
    tick = 1'b1;
    adv();
    adv();
    tick = 1'b0;
    checks++;
    if (state !== 3'd2 || env !== 8'd180)
      $display("FAIL ar_setup got=%0d/%0d want=2/180",
               state, env);
    else passed++;
    #2;
    arst = 1'b1;
    #1;
    checks++;
    if (env !== 8'd0 || state !== 3'd0 || active !== 1'b0)
      $display("FAIL ar_async got=%0d/%0d/%0b want=0/0/0",
               env, state, active);
    else passed++;
    #1;
    arst = 1'b0;
    model_reset();
    adv();
    checks++;
    if (state !== 3'd1 || env !== 8'd0)
      $display("FAIL ar_rearm got=%0d/%0d want=1/0",
               state, env);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 59) == 0) begin
        attack_rate = ($urandom_range(0, 5) == 0) ? 8'd0 :
                      8'($urandom_range(1, 255));
        decay_rate = ($urandom_range(0, 5) == 0) ? 8'd0 :
                     8'($urandom_range(1, 255));
        release_rate = ($urandom_range(0, 5) == 0) ? 8'd0 :
                       8'($urandom_range(1, 255));
        sustain_level = 8'($urandom_range(0, 255));
      end
      adv();
      checks++;
      if (env !== 8'(m_env) || state !== 3'(m_st) ||
          active !== (m_st != 0)) begin
        if (errs < 10)
          $display("FAIL rnd%0d got=%0d/%0d want=%0d/%0d",
                   i, env, state, m_env, m_st);
        errs++;
      end else passed++;
    end
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adsr_cycle();
    test_release();
    test_retrigger();
    test_zero_rate();
    test_coincident();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
